regfile_dump_reader: RTL

- Debug-side reader for the 32 x 32-bit CPU register file.
- On a start request it walks every register through one asynchronous read port, from r0 to r31.
- Each word is serialized into 4 bytes, MSB first, toward the UART transmitter over a valid/ready byte handshake.
- Sits between the register file read port and the debug-unit UART TX path. Only used while the pipeline is halted.

---
 rtl/regfile_dump_reader_pkg.sv | 17 +
 rtl/regfile_dump_reader_if.sv | 25 ++
 rtl/regfile_dump_reader_word_byte_serializer.sv | 56 +++++
 rtl/regfile_dump_reader.sv | 78 +++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// State encoding, byte geometry and byte-stream handshake levels.
package regfile_dump_reader_pkg;

    localparam int DBG_NB_BYTE = 8;
    localparam int DBG_NB_DATA = 32;
    localparam int DBG_BYTES_PER_WORD = DBG_NB_DATA / DBG_NB_BYTE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic TX_VALID_ON  = 1'b1;
    localparam logic TX_VALID_OFF = 1'b0;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Byte-stream valid/ready link toward the debug UART TX.
// The master presents bytes; the slave accepts them.
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int NB_BYTE = DBG_NB_BYTE
);

    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
// Latches one register word and emits it MSB byte first.
// Flags the cycle in which the final byte of the word is accepted.
module word_byte_serializer
    import regfile_dump_reader_pkg::*;
#(
    parameter int NB_DATA = DBG_NB_DATA,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [NB_DATA-1:0] word,
    regfile_dump_reader_if.master tx,
    output logic               last_accept
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_BYTES - 1);

    logic [NB_DATA-1:0] word_q;
    logic [NB_DATA-1:0] shifted;
    logic [NB_CNT-1:0]  cnt;
    logic               valid;
    logic               accept;

    assign accept      = valid && tx.tx_ready;
    assign last_accept = accept && (cnt == LAST_CNT);

    // Selected byte is moved to the top so the MSB slice is always used.
    assign shifted = word_q << (cnt * NB_BYTE);

    assign tx.tx_valid = valid;
    assign tx.tx_data  = valid ? shifted[NB_DATA-1 -: NB_BYTE] : '0;

    // Word latch, byte counter and valid flag; held steady until accepted.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            cnt    <= '0;
            valid  <= TX_VALID_OFF;
        end else if (load) begin
            word_q <= word;
            cnt    <= '0;
            valid  <= TX_VALID_ON;
        end else if (accept) begin
            if (cnt == LAST_CNT) begin
                valid <= TX_VALID_OFF;
            end else begin
                cnt <= cnt + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks r0..r(N_REGS-1) through the async read port and streams
// each word as bytes to the debug UART TX.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NB_DATA = DBG_NB_DATA,
    parameter int N_REGS  = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    regfile_dump_reader_if.master tx,
    output logic               o_busy,
    output logic               o_done
);

    // One extra index bit keeps the last-register compare from wrapping.
    localparam logic [NB_ADDR:0] LAST_IDX = (NB_ADDR + 1)'(N_REGS - 1);

    logic [1:0]       state;
    logic [NB_ADDR:0] idx;
    logic             last_accept;

    assign o_busy    = (state != ST_IDLE);
    assign o_done    = (state == ST_DONE);
    assign o_rd_addr = (state == ST_IDLE) ? '0 : idx[NB_ADDR-1:0];

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == ST_IDLE),
        .load        (state == ST_READ),
        .word        (i_rd_data),
        .tx          (tx),
        .last_accept (last_accept)
    );

    // Dump sequencing: read a word, send its bytes, advance or finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (i_start) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (last_accept) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + (NB_ADDR + 1)'(1);
                            state <= ST_READ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
